// File: rtl/eth_pkg.sv
// Shared types and constants for the Ethernet TX byte-path scheduler.
package eth_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    GRANT_ARP = 2'd1,
    GRANT_UDP = 2'd2,
    GAP       = 2'd3
  } tx_sched_state_t;

  localparam logic TX_SEL_ARP = 1'b0;
  localparam logic TX_SEL_UDP = 1'b1;

endpackage

// File: rtl/eth_tx_sched_sat_counter.sv
// Saturating event counter: counts inc pulses, holds at all-ones, clr wins.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         aclk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
    return (v == {W{1'b1}}) ? v : v + W'(1);
  endfunction

  always_ff @(posedge aclk) begin
    if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= sat_inc(cnt);
    end
  end

endmodule

// File: rtl/eth_tx_sched.sv
// Arbitrates the Ethernet TX byte path between ARP replies and UDP frames.
// Optional gratuitous-ARP timer and arp_grat output: define ETH_TX_SCHED_GRAT_EN.
module eth_tx_sched
  import eth_pkg::*;
#(
  parameter int IFG_CYCLES     = 12,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int ARP_BURST_MAX  = 4,
  parameter int CNT_W          = 8
`ifdef ETH_TX_SCHED_GRAT_EN
  ,
  parameter int GRAT_PERIOD    = 1 << 24
`endif
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             arp_req,
  output logic             arp_grant,
  input  logic             arp_done,
  input  logic             udp_req,
  output logic             udp_grant,
  input  logic             udp_done,
  output logic             tx_sel,
  output logic [CNT_W-1:0] arp_drop_cnt,
  output logic [CNT_W-1:0] timeout_cnt,
  output logic             busy
`ifdef ETH_TX_SCHED_GRAT_EN
  ,
  output logic             arp_grat
`endif
);

  localparam int BW = $clog2(ARP_BURST_MAX + 1);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int GW = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam tx_sched_state_t POST_GRANT = (IFG_CYCLES == 0) ? IDLE : GAP;

  tx_sched_state_t state_q, state_d;
  logic            arp_pend_q, arp_pend_d;
  logic [BW-1:0]   burst_q, burst_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [TW-1:0]   to_q, to_d;
  logic            tx_sel_q, tx_sel_d;
  logic            arp_take;
  logic            owner_done;
  logic            to_inc;
  logic            drop_inc;
  logic            cnt_clr;
  logic            grat_set;
  logic            grat_merge;

  always_comb begin
    state_d    = state_q;
    burst_d    = burst_q;
    gap_d      = '0;
    to_d       = '0;
    tx_sel_d   = tx_sel_q;
    arp_take   = 1'b0;
    to_inc     = 1'b0;
    owner_done = (state_q == GRANT_UDP) ? udp_done : arp_done;
    case (state_q)
      IDLE: begin
        // Only ARP grants issued while UDP waits count toward the starvation limit.
        if (!udp_req) begin
          burst_d = '0;
        end
        if (arp_pend_q && ((burst_q < BW'(ARP_BURST_MAX)) || !udp_req)) begin
          state_d  = GRANT_ARP;
          tx_sel_d = TX_SEL_ARP;
          arp_take = 1'b1;
          if (udp_req) begin
            burst_d = burst_q + BW'(1);
          end
        end else if (udp_req) begin
          state_d  = GRANT_UDP;
          tx_sel_d = TX_SEL_UDP;
          burst_d  = '0;
        end
      end
      GRANT_ARP, GRANT_UDP: begin
        if (owner_done) begin
          state_d = POST_GRANT;
        end else if (to_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_d = POST_GRANT;
          to_inc  = 1'b1;
        end else begin
          to_d = to_q + TW'(1);
        end
      end
      GAP: begin
        if (gap_q == GW'(IFG_CYCLES - 1)) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A request landing on the cycle its predecessor is taken simply re-arms the flag.
  assign arp_pend_d = arp_req || grat_set || (arp_pend_q && !arp_take);
  assign drop_inc   = arp_req && arp_pend_q && !arp_take && !grat_merge;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q    <= IDLE;
      arp_pend_q <= 1'b0;
      burst_q    <= '0;
      gap_q      <= '0;
      to_q       <= '0;
      tx_sel_q   <= TX_SEL_ARP;
    end else begin
      state_q    <= state_d;
      arp_pend_q <= arp_pend_d;
      burst_q    <= burst_d;
      gap_q      <= gap_d;
      to_q       <= to_d;
      tx_sel_q   <= tx_sel_d;
    end
  end

`ifdef ETH_TX_SCHED_GRAT_EN
  localparam int PW = (GRAT_PERIOD > 1) ? $clog2(GRAT_PERIOD) : 1;

  logic [PW-1:0] per_q;
  logic          grat_exp;
  logic          grat_flag_q;
  logic          arp_grat_q;

  // Expiry only raises a gratuitous reply when nothing else is already queued.
  assign grat_exp   = (per_q == PW'(GRAT_PERIOD - 1));
  assign grat_set   = grat_exp && !(arp_pend_q && !arp_take) && !arp_req;
  assign grat_merge = grat_flag_q;
  assign arp_grat   = arp_grat_q;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      per_q       <= '0;
      grat_flag_q <= 1'b0;
      arp_grat_q  <= 1'b0;
    end else begin
      per_q <= grat_exp ? '0 : per_q + PW'(1);
      if (grat_set) begin
        grat_flag_q <= 1'b1;
      end else if (arp_take || arp_req) begin
        grat_flag_q <= 1'b0;
      end
      if (arp_take) begin
        arp_grat_q <= grat_flag_q;
      end else if ((state_q == GRANT_ARP) && (state_d != GRANT_ARP)) begin
        arp_grat_q <= 1'b0;
      end
    end
  end
`else
  assign grat_set   = 1'b0;
  assign grat_merge = 1'b0;
`endif

  assign cnt_clr = !aresetn;

  sat_counter #(.W(CNT_W)) u_drop_cnt (
    .aclk (aclk),
    .clr  (cnt_clr),
    .inc  (drop_inc),
    .cnt  (arp_drop_cnt)
  );

  sat_counter #(.W(CNT_W)) u_timeout_cnt (
    .aclk (aclk),
    .clr  (cnt_clr),
    .inc  (to_inc),
    .cnt  (timeout_cnt)
  );

  assign arp_grant = (state_q == GRANT_ARP);
  assign udp_grant = (state_q == GRANT_UDP);
  assign busy      = (state_q != IDLE);
  assign tx_sel    = tx_sel_q;

endmodule
